// File: rtl/rd_pkg.sv
// Shared types and constants for the serial read-pattern generator.
package rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_REARM = 2'd2
    } state_e;

    // MODE input encodings; the unused value 3 behaves like MODE_UPDOWN.
    localparam logic [1:0] MODE_UPDOWN  = 2'd0;
    localparam logic [1:0] MODE_WALK1   = 2'd1;
    localparam logic [1:0] MODE_LANETAG = 2'd2;

endpackage

// File: rtl/rd_synchronizer.sv
// Two-flop synchronizer for a single asynchronous control input.
module rd_synchronizer (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Resample the asynchronous input twice before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rd_pattern_gen.sv
// Multi-lane serial test-pattern generator: on a trigger it emits NWORDS
// words per lane, MSB first, each followed by an odd-parity bit.
module rd_pattern_gen
    import rd_pkg::*;
#(
    parameter int NCHAN     = 2,
    parameter int WORD_BITS = 12,
    parameter int NWORDS    = 2048
) (
    input  logic             LOCAL_CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             TRIGGER,
    input  logic [1:0]       MODE,
    input  logic             PARITY_INV,
    output logic             ENABLE_XFR,
    output logic [NCHAN-1:0] SERIAL_OUT,
    output logic             WORD_STROBE,
    output logic [15:0]      WORD_COUNT,
    output logic             DONE
);

    localparam int             BCW       = $clog2(WORD_BITS + 1);
    localparam logic [BCW-1:0] PAR_POS   = BCW'(WORD_BITS);
    localparam logic [BCW-1:0] WALK_LAST = BCW'(WORD_BITS - 1);
    localparam logic [15:0]    LAST_WORD = 16'(NWORDS - 1);
    // Lane tag sits in the top four data bits; narrower words just add the lane index.
    localparam int             TAG_SHIFT = (WORD_BITS >= 4) ? WORD_BITS - 4 : 0;

    logic en_sync;
    logic trig_sync;
    logic trig_edge;

    state_e           state_q, state_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic [BCW-1:0]   walk_q, walk_d;
    logic [15:0]      word_q, word_d;
    logic [1:0]       mode_q, mode_d;
    logic             pinv_q, pinv_d;
    logic [15:0]      word_count_q, word_count_d;
    logic             xfr_q, xfr_d;
    logic [NCHAN-1:0] serial_q, serial_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic             trig_prev_q;

    rd_synchronizer u_sync_en (
        .clk   (LOCAL_CLK),
        .rst_n (RESET_N),
        .d     (ENABLE),
        .q     (en_sync)
    );

    rd_synchronizer u_sync_trig (
        .clk   (LOCAL_CLK),
        .rst_n (RESET_N),
        .d     (TRIGGER),
        .q     (trig_sync)
    );

    assign trig_edge = trig_sync & ~trig_prev_q;

    // Next-state logic for the transfer FSM, bit/word counters and latched controls.
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        walk_d       = walk_q;
        word_d       = word_q;
        mode_d       = mode_q;
        pinv_d       = pinv_q;
        word_count_d = word_count_q;
        done_d       = 1'b0;
        if (!en_sync) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_edge) begin
                        state_d      = ST_SEND;
                        bit_d        = '0;
                        walk_d       = '0;
                        word_d       = '0;
                        mode_d       = MODE;
                        pinv_d       = PARITY_INV;
                        word_count_d = '0;
                    end
                end
                ST_SEND: begin
                    if (bit_q == PAR_POS) begin
                        word_count_d = word_count_q + 16'd1;
                        bit_d        = '0;
                        if (word_q == LAST_WORD) begin
                            state_d = ST_REARM;
                            done_d  = 1'b1;
                        end else begin
                            word_d = word_q + 16'd1;
                            walk_d = (walk_q == WALK_LAST) ? '0 : walk_q + BCW'(1);
                        end
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end
                ST_REARM: begin
                    if (!trig_sync) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        xfr_d    = (state_d == ST_SEND);
        strobe_d = xfr_d && (bit_d == PAR_POS);
    end

    // Outputs are registered, so each lane's bit is derived from the next-state counters.
    for (genvar c = 0; c < NCHAN; c++) begin : g_lane
        logic [WORD_BITS-1:0] lane_word;
        logic [WORD_BITS-1:0] lane_shift;
        logic                 lane_par;
        logic                 lane_bit;

        // Build this lane's word for the current pattern and select the bit being sent.
        always_comb begin
            case (mode_d)
                MODE_WALK1:   lane_word = WORD_BITS'(1) << walk_d;
                MODE_LANETAG: lane_word = (WORD_BITS'(c) << TAG_SHIFT) + word_d[WORD_BITS-1:0];
                default: begin
                    if (c % 2 == 1) lane_word = -word_d[WORD_BITS-1:0];
                    else            lane_word = word_d[WORD_BITS-1:0];
                end
            endcase
            lane_par   = ~(^lane_word) ^ pinv_d;
            lane_shift = lane_word << bit_d;
            if (!xfr_d)                 lane_bit = 1'b0;
            else if (bit_d == PAR_POS)  lane_bit = lane_par;
            else                        lane_bit = lane_shift[WORD_BITS-1];
        end

        assign serial_d[c] = lane_bit;
    end

    // State, counters and registered outputs.
    always_ff @(posedge LOCAL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            bit_q        <= '0;
            walk_q       <= '0;
            word_q       <= '0;
            mode_q       <= '0;
            pinv_q       <= 1'b0;
            word_count_q <= '0;
            xfr_q        <= 1'b0;
            serial_q     <= '0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            trig_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            walk_q       <= walk_d;
            word_q       <= word_d;
            mode_q       <= mode_d;
            pinv_q       <= pinv_d;
            word_count_q <= word_count_d;
            xfr_q        <= xfr_d;
            serial_q     <= serial_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
            trig_prev_q  <= trig_sync;
        end
    end

    assign ENABLE_XFR  = xfr_q;
    assign SERIAL_OUT  = serial_q;
    assign WORD_STROBE = strobe_q;
    assign WORD_COUNT  = word_count_q;
    assign DONE        = done_q;

endmodule
